// File: rtl/aesl_deadlock_report_collector.sv
// Deadlock report collector: qualifies monitor block flags with a timeout and hands one report out.
// Define DEADLOCK_COLLECT_FALSE_ALARM_EN to build the recovered-episode counter.
module aesl_deadlock_report_collector #(
    parameter int NUM_MON = 4,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16,
    parameter int IDX_W   = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_MON-1:0] mon_block,
    input  logic               all_idle,
    input  logic               clear,
    output logic               deadlock,
    output logic [NUM_MON-1:0] culprit_mask,
    output logic [IDX_W-1:0]   first_idx,
    output logic [CNT_W-1:0]   stall_cycles,
    output logic               report_valid,
    input  logic               report_ready,
    output logic [CNT_W-1:0]   false_alarms
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WATCH  = 2'd1;
    localparam logic [1:0] ST_REPORT = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_M1   = CNT_W'(TIMEOUT - 1);

    logic [1:0]         state_q, state_d;
    logic               dl_q, dl_d;
    logic [NUM_MON-1:0] mask_q, mask_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic               vld_q, vld_d;
    logic [IDX_W-1:0]   low_idx;
    logic               any_blk;
    logic               recover;

    assign any_blk = |mon_block;

    always_comb begin
        low_idx = '0;
        for (int i = NUM_MON - 1; i >= 0; i--) begin
            if (mon_block[i]) low_idx = IDX_W'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        dl_d    = dl_q;
        mask_d  = mask_q;
        idx_d   = idx_q;
        stall_d = stall_q;
        vld_d   = vld_q;
        recover = 1'b0;
        if (clear) begin
            state_d = ST_IDLE;
            dl_d    = 1'b0;
            vld_d   = 1'b0;
            mask_d  = '0;
            stall_d = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_blk && !all_idle) begin
                        state_d = ST_WATCH;
                        stall_d = CNT_W'(1);
                        idx_d   = low_idx;
                    end
                end
                ST_WATCH: begin
                    // Idle beats recovery, recovery beats timeout.
                    if (all_idle) begin
                        state_d = ST_IDLE;
                    end else if (!any_blk) begin
                        state_d = ST_IDLE;
                        recover = 1'b1;
                    end else if (stall_q == TO_M1) begin
                        state_d = ST_REPORT;
                        dl_d    = 1'b1;
                        mask_d  = mon_block;
                        vld_d   = 1'b1;
                        stall_d = stall_q + 1'b1;
                    end else if (stall_q != CNT_MAX) begin
                        stall_d = stall_q + 1'b1;
                    end
                end
                ST_REPORT: begin
                    if (report_ready) begin
                        state_d = ST_DONE;
                        vld_d   = 1'b0;
                    end
                end
                ST_DONE: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            dl_q    <= 1'b0;
            mask_q  <= '0;
            idx_q   <= '0;
            stall_q <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dl_q    <= dl_d;
            mask_q  <= mask_d;
            idx_q   <= idx_d;
            stall_q <= stall_d;
            vld_q   <= vld_d;
        end
    end

`ifdef DEADLOCK_COLLECT_FALSE_ALARM_EN
    logic [CNT_W-1:0] fa_q, fa_d;

    always_comb begin
        fa_d = fa_q;
        if (recover && fa_q != CNT_MAX) fa_d = fa_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) fa_q <= '0;
        else       fa_q <= fa_d;
    end

    assign false_alarms = fa_q;
`else
    logic unused_recover;
    assign unused_recover = recover;
    assign false_alarms   = '0;
`endif

    assign deadlock     = dl_q;
    assign culprit_mask = mask_q;
    assign first_idx    = idx_q;
    assign stall_cycles = stall_q;
    assign report_valid = vld_q;

endmodule

// File: tb/tb_aesl_deadlock_report_collector.sv
// Directed bench for the deadlock report collector.
module tb_aesl_deadlock_report_collector;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  mon_block = '0;
    logic        all_idle = 1'b0;
    logic        clear = 1'b0;
    logic        report_ready = 1'b0;
    logic        deadlock;
    logic [3:0]  culprit_mask;
    logic [1:0]  first_idx;
    logic [15:0] stall_cycles;
    logic        report_valid;
    logic [15:0] false_alarms;

    int checks = 0;
    int failures = 0;
    int fa_exp = 0;
`ifdef DEADLOCK_COLLECT_FALSE_ALARM_EN
    localparam int FA_EN = 1;
`else
    localparam int FA_EN = 0;
`endif

    aesl_deadlock_report_collector dut (
        .clock(clock), .reset(reset), .mon_block(mon_block),
        .all_idle(all_idle), .clear(clear), .deadlock(deadlock),
        .culprit_mask(culprit_mask), .first_idx(first_idx),
        .stall_cycles(stall_cycles), .report_valid(report_valid),
        .report_ready(report_ready), .false_alarms(false_alarms)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic dl, input logic [3:0] m,
                           input logic [1:0] ix, input logic [15:0] st, input logic v);
        chk({tag, ".deadlock"}, 32'(deadlock), 32'(dl));
        chk({tag, ".mask"},     32'(culprit_mask), 32'(m));
        chk({tag, ".idx"},      32'(first_idx), 32'(ix));
        chk({tag, ".stall"},    32'(stall_cycles), 32'(st));
        chk({tag, ".valid"},    32'(report_valid), 32'(v));
        chk({tag, ".fa"},       32'(false_alarms), 32'(fa_exp));
    endtask

    initial begin
        tick(2);
        reset = 1'b0;
        chk_all("rst", 0, 4'h0, 0, 0, 0);

        // T1: single culprit, report held until ready
        mon_block = 4'b0100;
        tick(1);
        chk("t1.start", 32'(stall_cycles), 1);
        tick(1022);
        chk_all("t1.pre", 0, 4'h0, 2, 1023, 0);
        tick(1);
        chk_all("t1.to", 1, 4'b0100, 2, 1024, 1);
        mon_block = 4'b0000;
        tick(5);
        chk_all("t1.hold", 1, 4'b0100, 2, 1024, 1);
        report_ready = 1'b1;
        tick(1);
        report_ready = 1'b0;
        chk_all("t1.acc", 1, 4'b0100, 2, 1024, 0);
        mon_block = 4'b1111;
        tick(3);
        chk_all("t1.done", 1, 4'b0100, 2, 1024, 0);
        mon_block = 4'b0000;
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        chk_all("t1.clr", 0, 4'h0, 0, 0, 0);

        // T2: recovered episode
        mon_block = 4'b0001;
        tick(500);
        chk_all("t2.run", 0, 4'h0, 0, 500, 0);
        mon_block = 4'b0000;
        tick(1);
        fa_exp += FA_EN;
        chk_all("t2.rec", 0, 4'h0, 0, 500, 0);
        tick(2);
        chk("t2.held", 32'(stall_cycles), 500);

        // T3: culprit set grows mid-watch
        mon_block = 4'b0010;
        tick(10);
        chk("t3.idx", 32'(first_idx), 1);
        mon_block = 4'b0011;
        tick(1013);
        chk_all("t3.pre", 0, 4'h0, 1, 1023, 0);
        tick(1);
        chk_all("t3.to", 1, 4'b0011, 1, 1024, 1);
        clear = 1'b1;
        report_ready = 1'b1;
        tick(1);
        clear = 1'b0;
        report_ready = 1'b0;
        chk_all("t3.clr", 0, 4'h0, 0, 0, 0);
        mon_block = 4'b0000;
        tick(1);

        // T4: all_idle on the timeout cycle
        mon_block = 4'b1000;
        tick(1023);
        chk("t4.pre", 32'(stall_cycles), 1023);
        all_idle = 1'b1;
        tick(1);
        chk_all("t4.idle", 0, 4'h0, 3, 1023, 0);
        tick(3);
        chk_all("t4.stay", 0, 4'h0, 3, 1023, 0);
        all_idle = 1'b0;
        mon_block = 4'b0000;
        tick(1);

        // T5: clear on the timeout cycle, then restart
        mon_block = 4'b0100;
        tick(1023);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        chk_all("t5.clr", 0, 4'h0, 0, 0, 0);
        tick(1);
        chk_all("t5.restart", 0, 4'h0, 2, 1, 0);
        mon_block = 4'b0000;
        tick(1);
        fa_exp += FA_EN;
        chk("t5.fa", 32'(false_alarms), 32'(fa_exp));

        // drop of block exactly on the timeout cycle
        mon_block = 4'b0001;
        tick(1023);
        mon_block = 4'b0000;
        tick(1);
        fa_exp += FA_EN;
        chk_all("drop", 0, 4'h0, 0, 1023, 0);

        // T6: reset while reporting
        mon_block = 4'b0010;
        tick(1024);
        chk("t6.rep", 32'(report_valid), 1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        mon_block = 4'b0000;
        fa_exp = 0;
        chk_all("t6.rst", 0, 4'h0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
